// File: rtl/wb_commit_multi_pkg.sv
// Shared definitions for the write-back/commit stage: stall bus encoding,
// stall bit positions and lane bus field widths.
package wb_commit_multi_pkg;

    typedef logic [5:0] stall_bus_t;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam int   STALL_WB   = 4;
    localparam int   STALL_NEXT = 5;
    localparam int   PC_W       = 32;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int id_lane_w(input int ra_w, input int data_w);
        return 1 + ra_w + data_w;
    endfunction

    // Width of the full MEM->WB bundle: per-lane {valid, pc, we, waddr, wstrb, wdata} plus HI/LO.
    function automatic int mem_to_wb_wd(input int num_lanes, input int data_w, input int ra_w);
        return num_lanes * (1 + PC_W + 1 + ra_w + strb_w(data_w) + data_w) + 2 + 2 * data_w;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Debug trace FIFO: accepts up to NUM_LANES entries per cycle (packed in lane
// order), pops one per cycle, and presents the head (all-zero when empty).
module wb_trace_fifo
    import wb_commit_multi_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int RA_W      = 5,
    parameter int DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANES-1:0]           push_vld,
    input  logic [NUM_LANES*32-1:0]        push_pc,
    input  logic [NUM_LANES*(DATA_W/8)-1:0] push_wen,
    input  logic [NUM_LANES*RA_W-1:0]      push_waddr,
    input  logic [NUM_LANES*DATA_W-1:0]    push_wdata,
    output logic [$clog2(DEPTH):0]         count,
    output logic [31:0]                    head_pc,
    output logic [(DATA_W/8)-1:0]          head_wen,
    output logic [RA_W-1:0]                head_waddr,
    output logic [DATA_W-1:0]              head_wdata
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0]       pc;
        logic [STRB_W-1:0] wen;
        logic [RA_W-1:0]   waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] npush;
    logic [PTR_W-1:0] slot [NUM_LANES];
    logic             pop;

    // Each pushing lane lands after all older pushing lanes, so the trace stays in program order.
    always_comb begin
        npush = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot[i] = wptr + npush[PTR_W-1:0];
            if (push_vld[i]) npush = npush + CNT_W'(1);
        end
    end

    assign pop = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + npush[PTR_W-1:0];
            rptr <= rptr + PTR_W'(pop);
            cnt  <= cnt + npush - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push_vld[i]) begin
                mem[slot[i]] <= '{pc:    push_pc[i*32 +: 32],
                                  wen:   push_wen[i*STRB_W +: STRB_W],
                                  waddr: push_waddr[i*RA_W +: RA_W],
                                  wdata: push_wdata[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_comb begin
        head_pc    = '0;
        head_wen   = '0;
        head_waddr = '0;
        head_wdata = '0;
        if (pop) begin
            head_pc    = mem[rptr].pc;
            head_wen   = mem[rptr].wen;
            head_waddr = mem[rptr].waddr;
            head_wdata = mem[rptr].wdata;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane write-back/commit stage: latches the MEM bundle, commits it once
// to the RF and HI/LO ports, and serialises retirements onto the debug trace.
module wb_commit_multi
    import wb_commit_multi_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int DATA_W      = 32,
    parameter int RA_W        = 5,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  stall_bus_t                             stall,
    input  logic [NUM_LANES-1:0]                   mem_valid,
    input  logic [NUM_LANES*32-1:0]                mem_pc,
    input  logic [NUM_LANES-1:0]                   mem_we,
    input  logic [NUM_LANES*RA_W-1:0]              mem_waddr,
    input  logic [NUM_LANES*(DATA_W/8)-1:0]        mem_wstrb,
    input  logic [NUM_LANES*DATA_W-1:0]            mem_wdata,
    input  logic [1:0]                             mem_hilo_we,
    input  logic [DATA_W-1:0]                      mem_hi,
    input  logic [DATA_W-1:0]                      mem_lo,
    output logic [NUM_LANES-1:0]                   rf_we,
    output logic [NUM_LANES*RA_W-1:0]              rf_waddr,
    output logic [NUM_LANES*(DATA_W/8)-1:0]        rf_wstrb,
    output logic [NUM_LANES*DATA_W-1:0]            rf_wdata,
    output logic [1:0]                             hilo_we,
    output logic [DATA_W-1:0]                      hi_wdata,
    output logic [DATA_W-1:0]                      lo_wdata,
    output logic [NUM_LANES*(1+RA_W+DATA_W)-1:0]   wb_to_id_bus,
    output logic                                   stallreq_wb,
    output logic [31:0]                            debug_wb_pc,
    output logic [3:0]                             debug_wb_rf_wen,
    output logic [RA_W-1:0]                        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                      debug_wb_rf_wdata
);

    localparam int STRB_W = strb_w(DATA_W);
    localparam int LANE_W = id_lane_w(RA_W, DATA_W);
    localparam int CNT_W  = $clog2(TRACE_DEPTH) + 1;

    function automatic logic [CNT_W-1:0] lane_count(input logic [NUM_LANES-1:0] v);
        lane_count = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (v[i]) lane_count = lane_count + CNT_W'(1);
        end
    endfunction

    logic [NUM_LANES-1:0]        vld_p1, we_p1;
    logic [1:0]                  hilo_we_p1;
    logic                        occupied_p1, committed_p1;
    logic [NUM_LANES*32-1:0]     pc_p1;
    logic [NUM_LANES*RA_W-1:0]   waddr_p1;
    logic [NUM_LANES*STRB_W-1:0] wstrb_p1;
    logic [NUM_LANES*DATA_W-1:0] wdata_p1;
    logic [DATA_W-1:0]           hi_p1, lo_p1;

    logic                        stop_wb, bubble, load, fire;
    logic                        stall_unused;
    logic [CNT_W-1:0]            trace_cnt, free_slots, nvalid;
    logic [NUM_LANES-1:0]        wr_cand, push_vld;
    logic [NUM_LANES*STRB_W-1:0] push_wen;
    logic [STRB_W-1:0]           head_wen;

    assign stall_unused = ^stall[3:0];
    assign stop_wb      = (stall[STALL_WB] == STOP);

    // An uncommitted bundle is never replaced, whatever the stall bus says.
    assign load   = ~stallreq_wb & ~stop_wb;
    assign bubble = ~stallreq_wb & stop_wb & (stall[STALL_NEXT] == NO_STOP);

    // ---- MEM -> WB stage register (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= '0;
            we_p1        <= '0;
            hilo_we_p1   <= '0;
            occupied_p1  <= 1'b0;
            committed_p1 <= 1'b0;
        end else if (load) begin
            vld_p1       <= mem_valid;
            we_p1        <= mem_we;
            hilo_we_p1   <= mem_hilo_we;
            occupied_p1  <= |mem_valid;
            committed_p1 <= 1'b0;
        end else if (bubble) begin
            vld_p1       <= '0;
            we_p1        <= '0;
            hilo_we_p1   <= '0;
            occupied_p1  <= 1'b0;
            committed_p1 <= 1'b0;
        end else if (fire) begin
            committed_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pc_p1    <= mem_pc;
            waddr_p1 <= mem_waddr;
            wstrb_p1 <= mem_wstrb;
            wdata_p1 <= mem_wdata;
            hi_p1    <= mem_hi;
            lo_p1    <= mem_lo;
        end
    end

    // ---- commit (p1, combinational) ----
    assign nvalid      = lane_count(vld_p1);
    assign free_slots  = CNT_W'(TRACE_DEPTH) - trace_cnt;
    assign fire        = occupied_p1 & ~committed_p1 & (free_slots >= nvalid);
    assign stallreq_wb = occupied_p1 & ~committed_p1 & ~fire;

    // Same-cycle WAW: an older lane loses to any younger lane writing the same register.
    always_comb begin
        wr_cand = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_cand[i] = fire & vld_p1[i] & we_p1[i] & (waddr_p1[i*RA_W +: RA_W] != '0);
        end
        rf_we = wr_cand;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (wr_cand[j] && (waddr_p1[i*RA_W +: RA_W] == waddr_p1[j*RA_W +: RA_W])) begin
                    rf_we[i] = 1'b0;
                end
            end
        end
    end

    assign rf_waddr = waddr_p1;
    assign rf_wstrb = wstrb_p1;
    assign rf_wdata = wdata_p1;
    assign hilo_we  = fire ? hilo_we_p1 : 2'b00;
    assign hi_wdata = hi_p1;
    assign lo_wdata = lo_p1;

    always_comb begin
        wb_to_id_bus = '0;
        push_wen     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wb_to_id_bus[i*LANE_W +: LANE_W] = {vld_p1[i] & we_p1[i],
                                                 waddr_p1[i*RA_W +: RA_W],
                                                 wdata_p1[i*DATA_W +: DATA_W]};
            push_wen[i*STRB_W +: STRB_W] = we_p1[i] ? wstrb_p1[i*STRB_W +: STRB_W] : '0;
        end
    end

    assign push_vld = fire ? vld_p1 : '0;

    // ---- trace FIFO (p2 onwards) ----
    wb_trace_fifo #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .RA_W      (RA_W),
        .DEPTH     (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .push_vld   (push_vld),
        .push_pc    (pc_p1),
        .push_wen   (push_wen),
        .push_waddr (waddr_p1),
        .push_wdata (wdata_p1),
        .count      (trace_cnt),
        .head_pc    (debug_wb_pc),
        .head_wen   (head_wen),
        .head_waddr (debug_wb_rf_wnum),
        .head_wdata (debug_wb_rf_wdata)
    );

    assign debug_wb_rf_wen = 4'(head_wen);

endmodule

// File: tb/tb_wb_commit_multi.sv
// Self-checking bench for wb_commit_multi: table of single bundles, then
// hand-written HI/LO, stall, backpressure and reset-mid-drain sequences.
module tb_wb_commit_multi;

    localparam int NL = 2;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 1 + AW + DW;

    logic            clk, rst;
    logic [5:0]      stall;
    logic [NL-1:0]   mem_valid, mem_we;
    logic [NL*32-1:0] mem_pc;
    logic [NL*AW-1:0] mem_waddr;
    logic [NL*4-1:0] mem_wstrb;
    logic [NL*DW-1:0] mem_wdata;
    logic [1:0]      mem_hilo_we;
    logic [DW-1:0]   mem_hi, mem_lo;
    logic [NL-1:0]   rf_we;
    logic [NL*AW-1:0] rf_waddr;
    logic [NL*4-1:0] rf_wstrb;
    logic [NL*DW-1:0] rf_wdata;
    logic [1:0]      hilo_we;
    logic [DW-1:0]   hi_wdata, lo_wdata;
    logic [NL*LW-1:0] wb_to_id_bus;
    logic            stallreq_wb;
    logic [31:0]     debug_wb_pc;
    logic [3:0]      debug_wb_rf_wen;
    logic [AW-1:0]   debug_wb_rf_wnum;
    logic [DW-1:0]   debug_wb_rf_wdata;

    wb_commit_multi #(.NUM_LANES(NL), .DATA_W(DW), .RA_W(AW), .TRACE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_hilo_we(mem_hilo_we),
        .mem_hi(mem_hi), .mem_lo(mem_lo),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wstrb(rf_wstrb), .rf_wdata(rf_wdata),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .wb_to_id_bus(wb_to_id_bus), .stallreq_wb(stallreq_wb),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         valid;
        logic [1:0]         we;
        logic [1:0][AW-1:0] a;
        logic [1:0][3:0]    s;
        logic [1:0][DW-1:0] d;
        logic [1:0]         exp_we;
    } vec_t;

    typedef struct packed {
        logic [31:0]   pc;
        logic [3:0]    wen;
        logic [AW-1:0] wnum;
        logic [DW-1:0] wdata;
    } tr_t;

    tr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_rf_writes = 0;
    int          rf_wr_seen = 0;
    logic [31:0] pc_next = 32'hBFC0_0000;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                                input logic [AW-1:0] a0, input logic [3:0] s0, input logic [DW-1:0] d0,
                                input logic [AW-1:0] a1, input logic [3:0] s1, input logic [DW-1:0] d1,
                                input logic [1:0] exp_we);
        vec_t v;
        v.valid = valid; v.we = we;
        v.a[0] = a0; v.s[0] = s0; v.d[0] = d0;
        v.a[1] = a1; v.s[1] = s1; v.d[1] = d1;
        v.exp_we = exp_we;
        return v;
    endfunction

    task automatic set_bundle(input vec_t v, input logic [31:0] pc0);
        for (int i = 0; i < NL; i++) begin
            mem_valid[i]          = v.valid[i];
            mem_we[i]             = v.we[i];
            mem_pc[i*32 +: 32]    = pc0 + 32'(4 * i);
            mem_waddr[i*AW +: AW] = v.a[i];
            mem_wstrb[i*4 +: 4]   = v.s[i];
            mem_wdata[i*DW +: DW] = v.d[i];
        end
        mem_hilo_we = 2'b00;
    endtask

    // Drives a bundle that is expected to retire and records its expected trace entries.
    task automatic send(input vec_t v);
        tr_t e;
        set_bundle(v, pc_next);
        for (int i = 0; i < NL; i++) begin
            if (v.valid[i]) begin
                e.pc    = pc_next + 32'(4 * i);
                e.wen   = v.we[i] ? v.s[i] : 4'h0;
                e.wnum  = v.a[i];
                e.wdata = v.d[i];
                exp_q.push_back(e);
            end
        end
        exp_rf_writes += int'(v.exp_we[0]) + int'(v.exp_we[1]);
        pc_next += 32'd8;
    endtask

    task automatic idle();
        mem_valid   = '0;
        mem_we      = '0;
        mem_hilo_we = 2'b00;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Trace scoreboard and RF write counter
    always @(negedge clk) begin
        if (mon_en) begin
            rf_wr_seen += int'(rf_we[0]) + int'(rf_we[1]);
            if (debug_wb_pc != 32'h0) begin
                if (exp_q.size() == 0) begin
                    check("trace_unexpected_pc", 64'(debug_wb_pc), 64'h0);
                end else begin
                    tr_t e;
                    e = exp_q.pop_front();
                    check("trace_pc", 64'(debug_wb_pc), 64'(e.pc));
                    check("trace_wen", 64'(debug_wb_rf_wen), 64'(e.wen));
                    check("trace_wnum", 64'(debug_wb_rf_wnum), 64'(e.wnum));
                    check("trace_wdata", 64'(debug_wb_rf_wdata), 64'(e.wdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    vec_t tbl[10];
    vec_t bp[3];
    int   base;
    int   sent;
    bit   saw_stall;

    initial begin
        tbl[0] = mk(2'b01, 2'b01, 5'd3,  4'hF, 32'h1234,     5'd0,  4'hF, 32'h0,        2'b01);
        tbl[1] = mk(2'b11, 2'b11, 5'd5,  4'hF, 32'hA,        5'd6,  4'hF, 32'hB,        2'b11);
        tbl[2] = mk(2'b11, 2'b11, 5'd5,  4'hF, 32'hA,        5'd5,  4'hF, 32'hB,        2'b10);
        tbl[3] = mk(2'b01, 2'b01, 5'd0,  4'hF, 32'h55,       5'd0,  4'h0, 32'h0,        2'b00);
        tbl[4] = mk(2'b01, 2'b01, 5'd7,  4'h3, 32'hCAFE_F00D, 5'd0, 4'h0, 32'h0,        2'b01);
        tbl[5] = mk(2'b10, 2'b10, 5'd1,  4'hF, 32'h1,        5'd9,  4'hC, 32'h9999,     2'b10);
        tbl[6] = mk(2'b11, 2'b01, 5'd8,  4'hF, 32'h88,       5'd2,  4'hF, 32'h22,       2'b01);
        tbl[7] = mk(2'b11, 2'b11, 5'd0,  4'hF, 32'h10,       5'd0,  4'hF, 32'h20,       2'b00);
        tbl[8] = mk(2'b11, 2'b11, 5'd4,  4'hF, 32'h4444,     5'd4,  4'h3, 32'h5555,     2'b10);
        tbl[9] = mk(2'b00, 2'b11, 5'd4,  4'hF, 32'h1,        5'd5,  4'hF, 32'h2,        2'b00);
        bp[0]  = mk(2'b11, 2'b11, 5'd11, 4'hF, 32'hB0,       5'd12, 4'hF, 32'hB1,       2'b11);
        bp[1]  = mk(2'b11, 2'b11, 5'd13, 4'hF, 32'hB2,       5'd14, 4'hF, 32'hB3,       2'b11);
        bp[2]  = mk(2'b11, 2'b11, 5'd15, 4'hF, 32'hB4,       5'd16, 4'hF, 32'hB5,       2'b11);

        rst = 1'b1; stall = 6'b0;
        mem_pc = '0; mem_waddr = '0; mem_wstrb = '0; mem_wdata = '0;
        mem_hi = '0; mem_lo = '0;
        idle();
        repeat (3) @(negedge clk);
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_hilo_we", 64'(hilo_we), 64'd0);
        check("reset_stallreq", 64'(stallreq_wb), 64'd0);
        check("reset_dbg_pc", 64'(debug_wb_pc), 64'd0);
        check("reset_dbg_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("reset_dbg_wnum", 64'(debug_wb_rf_wnum), 64'd0);
        check("reset_dbg_wdata", 64'(debug_wb_rf_wdata), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Table of single bundles, each drained before the next
        for (int k = 0; k < 10; k++) begin
            send(tbl[k]);
            @(negedge clk);
            idle();
            check($sformatf("v%0d_rf_we", k), 64'(rf_we), 64'(tbl[k].exp_we));
            check($sformatf("v%0d_stallreq", k), 64'(stallreq_wb), 64'd0);
            check($sformatf("v%0d_hilo_we", k), 64'(hilo_we), 64'd0);
            for (int i = 0; i < NL; i++) begin
                if (tbl[k].exp_we[i]) begin
                    check($sformatf("v%0d_l%0d_waddr", k, i), 64'(rf_waddr[i*AW +: AW]), 64'(tbl[k].a[i]));
                    check($sformatf("v%0d_l%0d_wstrb", k, i), 64'(rf_wstrb[i*4 +: 4]), 64'(tbl[k].s[i]));
                    check($sformatf("v%0d_l%0d_wdata", k, i), 64'(rf_wdata[i*DW +: DW]), 64'(tbl[k].d[i]));
                end
            end
            if (k == 0) begin
                @(negedge clk);
                check("lat_dbg_pc", 64'(debug_wb_pc), 64'h0BFC0_0000);
                check("lat_dbg_wen", 64'(debug_wb_rf_wen), 64'hF);
                check("lat_dbg_wnum", 64'(debug_wb_rf_wnum), 64'd3);
                check("lat_dbg_wdata", 64'(debug_wb_rf_wdata), 64'h1234);
            end
            wait_drain($sformatf("v%0d_drain", k));
        end

        // HI/LO write, then a held stage must not write again
        send(mk(2'b01, 2'b00, 5'd0, 4'h0, 32'h0, 5'd0, 4'h0, 32'h0, 2'b00));
        mem_hilo_we = 2'b11; mem_hi = 32'h1111_2222; mem_lo = 32'h3333_4444;
        @(negedge clk);
        check("hilo_we", 64'(hilo_we), 64'd3);
        check("hi_wdata", 64'(hi_wdata), 64'h1111_2222);
        check("lo_wdata", 64'(lo_wdata), 64'h3333_4444);
        stall = 6'b110000;
        @(negedge clk);
        check("hilo_hold_we", 64'(hilo_we), 64'd0);
        stall = 6'b0;
        idle();
        wait_drain("hilo_drain");

        // Hold with stall[5:4]=11, then bubble with stall[5:4]=01
        send(mk(2'b01, 2'b01, 5'd10, 4'hF, 32'h77, 5'd0, 4'h0, 32'h0, 2'b01));
        @(negedge clk);
        check("stall_fire_rf_we", 64'(rf_we), 64'd1);
        stall = 6'b110000;
        set_bundle(mk(2'b11, 2'b11, 5'd20, 4'hF, 32'hDEAD, 5'd21, 4'hF, 32'hBEEF, 2'b00), 32'h8000_0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_rf_we", c), 64'(rf_we), 64'd0);
            check($sformatf("hold%0d_stallreq", c), 64'(stallreq_wb), 64'd0);
        end
        check("hold_id_bus", 64'(wb_to_id_bus[LW-1:0]), {26'd0, 1'b1, 5'd10, 32'h77});
        stall = 6'b010000;
        @(negedge clk);
        check("bubble_rf_we", 64'(rf_we), 64'd0);
        check("bubble_id_we", 64'(wb_to_id_bus[LW-1]), 64'd0);
        check("bubble_id_we1", 64'(wb_to_id_bus[2*LW-1]), 64'd0);
        stall = 6'b0;
        idle();
        wait_drain("stall_drain");

        // Backpressure: three back-to-back dual bundles into a 4-entry trace
        base = rf_wr_seen;
        sent = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 40 && !(sent == 3 && exp_q.size() == 0); c++) begin
            if (!stallreq_wb) begin
                if (sent < 3) begin
                    send(bp[sent]);
                    sent++;
                end else begin
                    idle();
                end
            end else begin
                saw_stall = 1'b1;
            end
            @(negedge clk);
        end
        idle();
        check("bp_stallreq_seen", 64'(saw_stall), 64'd1);
        check("bp_all_sent", 64'(sent), 64'd3);
        wait_drain("bp_drain");
        check("bp_rf_writes", 64'(rf_wr_seen - base), 64'd6);

        // Reset with three entries queued
        send(mk(2'b11, 2'b11, 5'd17, 4'hF, 32'hC0, 5'd18, 4'hF, 32'hC1, 2'b11));
        @(negedge clk);
        send(mk(2'b11, 2'b11, 5'd19, 4'hF, 32'hC2, 5'd22, 4'hF, 32'hC3, 2'b11));
        @(negedge clk);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_dbg_pc", 64'(debug_wb_pc), 64'd0);
        check("rstmid_dbg_wen", 64'(debug_wb_rf_wen), 64'd0);
        check("rstmid_dbg_wnum", 64'(debug_wb_rf_wnum), 64'd0);
        check("rstmid_dbg_wdata", 64'(debug_wb_rf_wdata), 64'd0);
        check("rstmid_stallreq", 64'(stallreq_wb), 64'd0);
        check("rstmid_rf_we", 64'(rf_we), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        check("rstmid_stays_empty", 64'(debug_wb_pc), 64'd0);

        check("total_rf_writes", 64'(rf_wr_seen), 64'(exp_rf_writes));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
